// File: rtl/qr_vector_driver_if.sv
// qr_vector_driver_if: element input stream and back-pressured result stream of the vector driver
interface qr_vector_driver_if;
  logic         in_valid;
  logic         in_ready;
  logic [47:0]  in_a_r;
  logic [47:0]  in_a_i;
  logic [11:0]  in_sigma;
  logic         res_valid;
  logic         res_ready;
  logic [199:0] res_data;
  modport master (output in_valid, in_a_r, in_a_i, in_sigma, res_ready, input in_ready, res_valid, res_data);
  modport slave (input in_valid, in_a_r, in_a_i, in_sigma, res_ready, output in_ready, res_valid, res_data);
endinterface

// File: rtl/qr_vector_driver.sv
// qr_vector_driver: packs matrix elements into the QR core test vector and unpacks results into a 2-deep result stream
module qr_vector_driver #(
  parameter int NUM_IN  = 16,
  parameter int NUM_OUT = 32,
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_start,
  input  logic                cfg_reduced,
  qr_vector_driver_if.slave   bus,
  output logic [110:0]        test_vector,
  input  logic [201:0]        result_vector,
  output logic                busy,
  output logic                done,
  output logic                timeout_err
);
  localparam int EW = $clog2(NUM_IN + 1);
  localparam int BW = $clog2(NUM_OUT + 1);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_READY, UNLOAD, DRAIN, ABORT} state_t;
  state_t state, nxt;
  logic [EW-1:0] ecnt;
  logic [BW-1:0] bcnt;
  logic [CNT_W-1:0] tcnt;
  logic [47:0] a_r, a_i;
  logic [11:0] sigma;
  logic reduced, start;
  logic [199:0] fifo [2];
  logic rd_ptr, wr_ptr;
  logic [1:0] count;
  logic beat, last_in, push, pop, req, tmo, counting;
  always_comb begin
    beat = state == LOAD && bus.in_valid;
    last_in = ecnt == EW'(NUM_IN - 1);
    push = state == UNLOAD && result_vector[200] && count != 2'd2;
    pop = count != '0 && bus.res_ready;
    req = state == UNLOAD && (count == '0 || (count == 2'd1 && bus.res_ready));
    tmo = tcnt == CNT_W'(TIMEOUT - 1);
    counting = (state == WAIT_READY && !result_vector[201]) || (state == UNLOAD && !push);
    done = state == DRAIN && count == '0;
    busy = state != IDLE && state != ABORT && !done;
    bus.in_ready = state == LOAD;
    bus.res_valid = count != '0;
    bus.res_data = fifo[rd_ptr];
    test_vector = {req, start, reduced, sigma, a_i, a_r};
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:       nxt = cmd_start ? LOAD : IDLE;
      LOAD:       nxt = beat && last_in ? WAIT_READY : LOAD;
      WAIT_READY: nxt = result_vector[201] ? UNLOAD : tmo ? ABORT : WAIT_READY;
      UNLOAD:     nxt = push ? (bcnt == BW'(NUM_OUT - 1) ? DRAIN : UNLOAD) : tmo ? ABORT : UNLOAD;
      DRAIN:      nxt = done ? IDLE : DRAIN;
      default:    nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ecnt <= '0;
      bcnt <= '0;
      tcnt <= '0;
      a_r <= '0;
      a_i <= '0;
      sigma <= '0;
      reduced <= 1'b0;
      start <= 1'b0;
      fifo[0] <= '0;
      fifo[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count <= '0;
      timeout_err <= 1'b0;
    end else begin
      start <= beat && ecnt == '0;
      tcnt <= counting ? tcnt + CNT_W'(tcnt != '1) : '0;
      rd_ptr <= rd_ptr ^ pop;
      wr_ptr <= wr_ptr ^ push;
      count <= count + 2'(push) - 2'(pop);
      if (state == IDLE && cmd_start) begin
        ecnt <= '0;
        bcnt <= '0;
        reduced <= cfg_reduced;
        timeout_err <= 1'b0;
      end
      if (beat) begin
        a_r <= bus.in_a_r;
        a_i <= bus.in_a_i;
        ecnt <= ecnt + EW'(ecnt != EW'(NUM_IN));
      end
      if (beat && ecnt == '0) sigma <= bus.in_sigma;
      if (push) begin
        fifo[wr_ptr] <= result_vector[199:0];
        bcnt <= bcnt + BW'(bcnt != BW'(NUM_OUT));
      end
      // a beat offered into a full FIFO breaks the core contract and is dropped
      if (state == UNLOAD && result_vector[200] && count == 2'd2) timeout_err <= 1'b1;
      if (nxt == ABORT) begin
        timeout_err <= 1'b1;
        reduced <= 1'b0;
        count <= '0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end
    end
  end
endmodule
